// File: rtl/gru_mem_pkg.sv
// rtl/gru_mem_pkg.sv - shared widths and burst FSM states for the GRU memory path
package gru_mem_pkg;

   localparam int GRU_ADDR_WIDTH = 8;
   localparam int GRU_DATA_WIDTH = 32;
   localparam int GRU_LEN_WIDTH  = GRU_ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } burst_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with occupancy count
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_push_data,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end
      return p + PW'(1);
   endfunction

   // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle
   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_empty    = (r_count == '0);

   // Storage write; contents need no reset because the count gates every read
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - burst read initiator streaming memory words downstream
module mem_burst_reader
   import gru_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = GRU_ADDR_WIDTH,
   parameter int DATA_WIDTH = GRU_DATA_WIDTH,
   parameter int LEN_WIDTH  = GRU_LEN_WIDTH,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
);

   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int CW  = $clog2(FIFO_DEPTH + 2) + 2;

   burst_state_t          r_state;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic [LEN_WIDTH-1:0]  r_remaining;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_busy;
   logic                  r_done;
   logic [1:0]            r_inflight;
   logic [1:0]            r_inflight_last;
   logic                  r_out_valid;
   logic                  r_out_last;
   logic [DATA_WIDTH-1:0] r_out_data;

   logic                  w_pop;
   logic                  w_arrive;
   logic                  w_load;
   logic                  w_issue;
   logic                  w_fifo_push;
   logic                  w_fifo_pop;
   logic                  w_fifo_empty;
   logic [FCW-1:0]        w_fifo_count;
   logic [DATA_WIDTH:0]   w_fifo_data;
   logic [CW-1:0]         w_need;
   logic [CW-1:0]         w_cap;

   assign mem_we      = 1'b0;
   assign mem_data_in = '0;
   assign mem_addr    = r_mem_addr;
   assign busy        = r_busy;
   assign done        = r_done;
   assign m_valid     = r_out_valid;
   assign m_data      = r_out_data;
   assign m_last      = r_out_last;

   // The output register acts as one extra buffer slot in front of the FIFO, so two
   // reads can be in flight while a word waits, giving 1 word/clk without overflow.
   assign w_pop        = r_out_valid & m_ready;
   assign w_arrive     = r_inflight[1];
   assign w_load       = ~r_out_valid | w_pop;
   assign w_fifo_pop   = w_load & ~w_fifo_empty;
   assign w_fifo_push  = w_arrive & ~(w_load & w_fifo_empty);

   // Issue only if every word already buffered or in flight, plus this one, fits even
   // if the consumer stalls from now on; a pop this cycle frees one slot.
   assign w_need  = CW'(w_fifo_count) + CW'(r_out_valid) + CW'(r_inflight[0])
                  + CW'(r_inflight[1]) + CW'(1);
   assign w_cap   = CW'(FIFO_DEPTH + 1) + CW'(w_pop);
   assign w_issue = (r_state == ST_ISSUE) && (r_remaining != '0) && (w_need <= w_cap);

   sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_fifo_push),
      .i_push_data ({r_inflight_last[1], mem_data_out}),
      .i_pop       (w_fifo_pop),
      .o_pop_data  (w_fifo_data),
      .o_count     (w_fifo_count),
      .o_empty     (w_fifo_empty)
   );

   // Burst FSM with address/remaining counters and registered busy/done/mem_addr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_next_addr <= '0;
         r_remaining <= '0;
         r_mem_addr  <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  if (length == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= ST_ISSUE;
                     r_busy      <= 1'b1;
                     r_next_addr <= base_addr;
                     r_remaining <= length;
                  end
               end
            end
            ST_ISSUE: begin
               if (w_issue) begin
                  r_mem_addr  <= r_next_addr;
                  r_next_addr <= r_next_addr + ADDR_WIDTH'(1);
                  r_remaining <= r_remaining - LEN_WIDTH'(1);
                  if (r_remaining == LEN_WIDTH'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_pop && r_out_last) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Two-stage tag shift marking which cycles carry valid (and final) read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inflight      <= 2'b00;
         r_inflight_last <= 2'b00;
      end else begin
         r_inflight      <= {r_inflight[0], w_issue};
         r_inflight_last <= {r_inflight_last[0], w_issue && (r_remaining == LEN_WIDTH'(1))};
      end
   end

   // Output stage: refill from the FIFO head first, else take arriving data directly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else if (w_load) begin
         if (!w_fifo_empty) begin
            r_out_valid <= 1'b1;
            r_out_last  <= w_fifo_data[DATA_WIDTH];
            r_out_data  <= w_fifo_data[DATA_WIDTH-1:0];
         end else if (w_arrive) begin
            r_out_valid <= 1'b1;
            r_out_last  <= r_inflight_last[1];
            r_out_data  <= mem_data_out;
         end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_burst_reader.sv
// tb/tb_mem_burst_reader.sv - self-checking bench for mem_burst_reader
module tb_mem_burst_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  length;
   logic        busy;
   logic        done;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [256];

   typedef struct {
      logic [7:0] base;
      logic [8:0] len;
      int         mode;
      bit         dup;
      int         exp_first;
      int         exp_done;
   } vec_t;

   vec_t vecs[9];
   int   pat[6] = '{1, 0, 0, 1, 0, 1};

   mem_burst_reader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .length       (length),
      .busy         (busy),
      .done         (done),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_data_out <= mem[mem_addr];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic run_burst(input logic [7:0] b, input logic [8:0] n, input int mode,
                            input bit dup, input int exp_first, input int exp_done);
      logic [31:0] exp_q[$];
      int          k;
      int          nbeats;
      int          first_cyc;
      int          done_cyc;
      int          done_cnt;
      int          post;
      int          bad_stall;
      int          bad_data;
      int          bad_last;
      int          bad_busy;
      int          bad_post;
      bit          finished;
      bit          rdy;
      bit          prev_v;
      bit          prev_r;
      logic [31:0] prev_d;
      logic        prev_l;
      logic [7:0]  addr0;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[8'(int'(b) + i)]);
      k = 0; nbeats = 0; first_cyc = -1; done_cyc = -1; done_cnt = 0; post = 0;
      bad_stall = 0; bad_data = 0; bad_last = 0; bad_busy = 0; bad_post = 0;
      finished = 0; prev_v = 0; prev_r = 0; prev_d = '0; prev_l = 0;
      @(negedge clk);
      addr0 = mem_addr;
      while (!finished && k < 2000) begin
         start     = (k == 0) || (dup && k == 2);
         base_addr = (dup && k == 2) ? b + 8'h40 : b;
         length    = (dup && k == 2) ? 9'd3 : n;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = pat[k % 6] != 0;
            2:       rdy = $urandom_range(0, 1) != 0;
            default: rdy = (k < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
         endcase
         m_ready = rdy;
         if (prev_v && !prev_r && !(m_valid && m_data == prev_d && m_last == prev_l))
            bad_stall++;
         if (k == 2 && n != 0) chk("first_mem_addr", mem_addr, b);
         if (m_valid && rdy) begin
            if (nbeats == 0) first_cyc = k;
            if (nbeats < int'(n)) begin
               if (m_data !== exp_q[nbeats]) begin
                  bad_data++;
                  $display("FAIL beat_data idx %0d got %0h want %0h", nbeats, m_data, exp_q[nbeats]);
               end
               if (m_last !== (nbeats == int'(n) - 1)) bad_last++;
            end
            nbeats++;
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = k;
            if (busy) bad_busy++;
         end
         if (n == 0 && busy) bad_busy++;
         if (done_cnt > 0 && !done && (busy || m_valid)) bad_post++;
         if (done_cnt > 0) post++;
         if (post == 4) finished = 1;
         prev_v = m_valid; prev_r = rdy; prev_d = m_data; prev_l = m_last;
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      m_ready = 1'b0;
      if (!finished) begin
         errors++;
         $display("FAIL burst_timeout base %0h len %0d", b, n);
      end
      chk("beat_count", nbeats, n);
      chk("done_count", done_cnt, 1);
      chk("stall_stable_viol", bad_stall, 0);
      chk("data_viol", bad_data, 0);
      chk("last_viol", bad_last, 0);
      chk("busy_viol", bad_busy, 0);
      chk("post_done_viol", bad_post, 0);
      chk("mem_we", mem_we, 0);
      chk("mem_data_in", mem_data_in, 0);
      if (exp_first >= 0) chk("first_beat_cycle", first_cyc, exp_first);
      if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
      if (n == 0) chk("len0_addr_hold", mem_addr, addr0);
   endtask

   initial begin
      int nb;
      int viol;
      vecs[0] = '{8'h10, 9'd4,   0, 1'b0,  4,   8};
      vecs[1] = '{8'hFE, 9'd4,   0, 1'b0,  4,   8};
      vecs[2] = '{8'h20, 9'd4,   1, 1'b0, -1,  -1};
      vecs[3] = '{8'h55, 9'd0,   0, 1'b0, -1,   1};
      vecs[4] = '{8'h30, 9'd4,   0, 1'b1,  4,   8};
      vecs[5] = '{8'hF0, 9'd256, 0, 1'b0,  4, 260};
      vecs[6] = '{8'h00, 9'd1,   0, 1'b0,  4,   5};
      vecs[7] = '{8'h80, 9'd37,  3, 1'b0, -1,  -1};
      vecs[8] = '{8'hC7, 9'd9,   1, 1'b1, -1,  -1};

      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
      rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_mem_addr", mem_addr, 0);
      chk("reset_m_valid", m_valid, 0);
      chk("reset_m_last", m_last, 0);
      chk("reset_m_data", m_data, 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].dup,
                   vecs[i].exp_first, vecs[i].exp_done);

      // Reset in the middle of a burst
      @(negedge clk);
      start = 1'b1; base_addr = 8'h40; length = 9'd8; m_ready = 1'b1; nb = 0;
      for (int k = 0; k < 40 && nb < 2; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (m_valid && m_ready) nb++;
      end
      chk("abort_beats_before_reset", nb, 2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_mem_addr", mem_addr, 0);
      chk("abort_m_valid", m_valid, 0);
      chk("abort_m_last", m_last, 0);
      chk("abort_m_data", m_data, 0);
      @(negedge clk);
      rst = 1'b0;
      viol = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (m_valid || done || busy) viol++;
      end
      chk("abort_quiet", viol, 0);
      run_burst(8'h40, 9'd8, 0, 1'b0, 4, 12);

      // Randomised bursts over random memory contents
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      for (int t = 0; t < 14; t++) begin
         logic [7:0] rb;
         logic [8:0] rl;
         rb = 8'($urandom_range(0, 255));
         rl = ($urandom_range(0, 6) == 0) ? 9'd0 : 9'($urandom_range(1, 40));
         run_burst(rb, rl, int'($urandom_range(2, 3)), (rl != 0) && ($urandom_range(0, 1) != 0), -1, -1);
      end
      run_burst(8'hFF, 9'd256, 2, 1'b0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
